counter_ud_checker: RTL and testbench
=====================================

// Module: counter_ud_checker
// PURPOSE
//  Receive-side monitor for the 8-bit up/down even/odd counter output bus.
//  - Undoes the output polarity of the sampled bus.
//  - Recovers the count direction (ud) and the parity mode (oe) from consecutive samples.
//  - Declares lock once the stream has been steady for long enough, and flags illegal steps.
//  - Sits beside the counter in the test fabric, or after a board link, as a self-checking sink.
// PARAMETERS
//  N         8   bus/count width; arithmetic is modulo 2^N
//  LOCK_CNT  4   consecutive matching steady steps required to assert locked (>=1)
//  ECW       8   width of saturating error counter
// PORTS
//  clk       in   1    rising-edge clock
//  reset     in   1    asynchronous, active-high reset
//  en        in   1    sample strobe; q_in is consumed on edges where en=1
//  inv       in   1    polarity: 1 = q_in is true value, 0 = q_in is complemented
//  q_in      in   N    counter output bus
//  value     out  N    last decoded sample (registered)
//  ud_det    out  1    recovered direction: 1 = up, 0 = down (valid while locked)
//  oe_det    out  1    recovered mode: 1 = even stream, 0 = odd stream (valid while locked)
//  locked    out  1    high while FSM is in LOCKED
//  mode_chg  out  1    1-cycle pulse: LOCKED left because of a legal direction/parity change
//  err       out  1    1-cycle pulse: illegal step detected
//  err_cnt   out  ECW  count of err pulses, saturates at all-ones
// BEHAVIOUR
//  - Reset values: all outputs 0; FSM in IDLE; prev, cnt, cand_ud and cand_oe are 0.
//  - Decode: c = inv ? q_in : ~q_in. The inv value is applied per sample.
//  - Timing: all outputs are registered on the edge that takes the sample. Latency is 1 clk.
//  - en=0: no state changes; value and the status outputs hold; pulses are 0.
//  - Step: d = (c - prev) mod 2^N.
//    - d==1 -> +1; d==2 -> +2; d==2^N-1 -> -1; d==2^N-2 -> -2.
//    - Any other d, including 0 (a stall), is BAD.
//    - Wrap is legal: 254 -> 0 is +2, and 0 -> 255 is -1.
//  - Steady step: magnitude 2. Its direction is dir = (step>0) and its parity is par = ~c[0].
//  - FSM states: IDLE, ACQ, LOCKED.
//    - IDLE: on en, prev <= c, cnt <= 0, go to ACQ. No error is possible on the first sample.
//    - ACQ, on en:
//      - BAD -> err pulse, err_cnt++, cnt <= 0, stay in ACQ.
//      - Magnitude 1 -> cand_ud <= dir, cand_oe <= ~c[0], cnt <= 0.
//      - Steady step and (dir,par) == (cand_ud,cand_oe) -> cnt++.
//        - If cnt+1 == LOCK_CNT: go to LOCKED, ud_det <= cand_ud, oe_det <= cand_oe.
//      - Steady step with a mismatch -> cand <= (dir,par), cnt <= 1.
//      - LOCK_CNT=1 locks on the first steady step.
//    - LOCKED, on en:
//      - Steady step matching (ud_det,oe_det) -> stay.
//      - Magnitude 1, or a steady mismatch -> mode_chg pulse, go to ACQ.
//        - The candidate and cnt update exactly as the ACQ rules above.
//      - BAD -> err pulse, err_cnt++, go to ACQ with cnt <= 0.
//    - prev <= c on every en sample in ACQ and LOCKED, including BAD samples.
//  - ud_det and oe_det change only on entry to LOCKED; they hold otherwise.
//  - err_cnt at all-ones: err still pulses, the count stays at all-ones.
//  - err and mode_chg are mutually exclusive; BAD takes precedence.
//  - Reset mid-operation: immediate return to reset values.
//    - The first sample after reset is never flagged.
// STRUCTURE
//  - Shared package counter_pkg:
//    - step_t enum {STEP_P1, STEP_P2, STEP_M1, STEP_M2, STEP_BAD}
//    - chk_state_t enum {IDLE, ACQ, LOCKED}
//    - default constants for N and LOCK_CNT
//  - One sub-module, counter_step_classify: purely combinational.
//    - Takes (prev, c) and returns step_t, dir and par.
//    - Instantiated once.
//  - The top level holds the FSM, the cnt/cand registers and the err_cnt saturator.
// TESTING  (N=8, LOCK_CNT=4)
//  1. inv=1, en=1; q_in = 0,2,4,6,8
//     -> locked rises on the edge taking 8; ud_det=1, oe_det=1; err never set.
//  2. inv=0; q_in = ~{251,253,255,1,3}
//     -> value = 251..3; lock on 3 with ud_det=1, oe_det=0; the 255->1 wrap is not an error.
//  3. Locked on even-up at 10; then q_in 12, 11, 9, 7, 5, 3
//     -> mode_chg pulses on 11; relocks on 3 with ud_det=0, oe_det=0.
//  4. Locked even-up at 20; then q_in 20 (stall), then 40
//     -> err pulses twice; err_cnt=2; locked=0; samples 42,44,46,48 relock.
//  5. Toggle en=0 for 3 cycles mid-stream, with q_in changing meanwhile
//     -> no state or value change; resume 50,52 with no error.
//  6. Assert reset while LOCKED with err_cnt=2
//     -> all outputs 0 asynchronously; next sample 77 produces no err.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and defaults for the up/down even/odd counter checker.
//   step_t      : classification of one sample-to-sample step
//   chk_state_t : checker FSM states
package counter_pkg;

  localparam int N_DEF        = 8;
  localparam int LOCK_CNT_DEF = 4;
  localparam int ECW_DEF      = 8;

  typedef enum logic [2:0] {
    STEP_P1,
    STEP_P2,
    STEP_M1,
    STEP_M2,
    STEP_BAD
  } step_t;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } chk_state_t;

endpackage

// File: rtl/counter_step_classify.sv
// Combinational step classifier.
//   prev : previous decoded sample
//   c    : current decoded sample
//   step : +1 / +2 / -1 / -2 / BAD, with arithmetic modulo 2^N
//   dir  : 1 when the step is positive
//   par  : parity mode implied by the current sample (1 = even stream)
module counter_step_classify
  import counter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] prev,
  input  logic [N-1:0] c,
  output step_t        step,
  output logic         dir,
  output logic         par
);

  logic [N-1:0] d;

  always_comb begin
    d    = c - prev;
    step = STEP_BAD;
    dir  = 1'b0;
    par  = ~c[0];
    if (d == N'(1)) begin
      step = STEP_P1;
      dir  = 1'b1;
    end else if (d == N'(2)) begin
      step = STEP_P2;
      dir  = 1'b1;
    end else if (d == {N{1'b1}}) begin
      step = STEP_M1;
    end else if (d == {{(N-1){1'b1}}, 1'b0}) begin
      step = STEP_M2;
    end
  end

endmodule

// File: rtl/counter_ud_checker.sv
// Receive-side monitor for the up/down even/odd counter output bus.
// Undoes bus polarity, recovers direction and parity mode, declares lock
// after LOCK_CNT matching steady (+/-2) steps and flags illegal steps.
//   clk, reset : clock, asynchronous active-high reset
//   en         : sample strobe
//   inv        : 1 = q_in is true value, 0 = q_in is complemented
//   q_in       : counter bus
//   value      : last decoded sample
//   ud_det     : recovered direction (1 = up), updated on lock entry only
//   oe_det     : recovered mode (1 = even), updated on lock entry only
//   locked     : FSM in LOCKED
//   mode_chg   : pulse, lock dropped by a legal direction/parity change
//   err        : pulse, illegal step
//   err_cnt    : saturating count of err pulses
module counter_ud_checker
  import counter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int LOCK_CNT = LOCK_CNT_DEF,
  parameter int ECW      = ECW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic           inv,
  input  logic [N-1:0]   q_in,
  output logic [N-1:0]   value,
  output logic           ud_det,
  output logic           oe_det,
  output logic           locked,
  output logic           mode_chg,
  output logic           err,
  output logic [ECW-1:0] err_cnt
);

  // cnt must be able to hold LOCK_CNT itself
  localparam int CW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  chk_state_t     state_q, state_d;
  logic [N-1:0]   prev_q, prev_d;
  logic [N-1:0]   value_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cand_ud_q, cand_ud_d;
  logic           cand_oe_q, cand_oe_d;
  logic           ud_d, oe_d, mc_d, err_d;
  logic [ECW-1:0] ecnt_d;

  logic [N-1:0]   c;
  step_t          step;
  logic           dir, par;
  logic           steady, match_cand, match_lock;

  assign c = inv ? q_in : ~q_in;

  counter_step_classify #(.N(N)) u_classify (
    .prev (prev_q),
    .c    (c),
    .step (step),
    .dir  (dir),
    .par  (par)
  );

  assign steady     = (step == STEP_P2) || (step == STEP_M2);
  assign match_cand = (dir == cand_ud_q) && (par == cand_oe_q);
  assign match_lock = (dir == ud_det) && (par == oe_det);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    value_d   = value;
    cnt_d     = cnt_q;
    cand_ud_d = cand_ud_q;
    cand_oe_d = cand_oe_q;
    ud_d      = ud_det;
    oe_d      = oe_det;
    mc_d      = 1'b0;
    err_d     = 1'b0;
    ecnt_d    = err_cnt;
    if (en) begin
      value_d = c;
      prev_d  = c;
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ACQ;
        end
        ACQ, LOCKED: begin
          if (step == STEP_BAD) begin
            err_d   = 1'b1;
            ecnt_d  = (&err_cnt) ? err_cnt : err_cnt + ECW'(1);
            cnt_d   = '0;
            state_d = ACQ;
          end else if ((state_q == LOCKED) && steady && match_lock) begin
            state_d = LOCKED;
          end else begin
            mc_d    = (state_q == LOCKED);
            state_d = ACQ;
            cand_ud_d = dir;
            cand_oe_d = par;
            if (!steady) begin
              cnt_d = '0;
            end else begin
              cnt_d = match_cand ? cnt_q + CW'(1) : CW'(1);
              // a steady step that completes the run locks, including
              // the very first one when LOCK_CNT is 1
              if (cnt_d == CW'(LOCK_CNT)) begin
                state_d = LOCKED;
                ud_d    = dir;
                oe_d    = par;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      value     <= '0;
      cnt_q     <= '0;
      cand_ud_q <= 1'b0;
      cand_oe_q <= 1'b0;
      ud_det    <= 1'b0;
      oe_det    <= 1'b0;
      mode_chg  <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      value     <= value_d;
      cnt_q     <= cnt_d;
      cand_ud_q <= cand_ud_d;
      cand_oe_q <= cand_oe_d;
      ud_det    <= ud_d;
      oe_det    <= oe_d;
      mode_chg  <= mc_d;
      err       <= err_d;
      err_cnt   <= ecnt_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_counter_ud_checker.sv
// Scoreboard bench for counter_ud_checker: stimulus pushes hand-computed
// expectations, a monitor pops and compares one entry per clock.
module tb_counter_ud_checker;

  logic       clk;
  logic       reset;
  logic       en;
  logic       inv;
  logic [7:0] q_in;
  logic [7:0] value;
  logic       ud_det, oe_det, locked, mode_chg, err;
  logic [7:0] err_cnt;

  typedef struct {
    logic [20:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  counter_ud_checker #(.N(8), .LOCK_CNT(4), .ECW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .inv      (inv),
    .q_in     (q_in),
    .value    (value),
    .ud_det   (ud_det),
    .oe_det   (oe_det),
    .locked   (locked),
    .mode_chg (mode_chg),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] outs();
    return {value, locked, ud_det, oe_det, mode_chg, err, err_cnt};
  endfunction

  // t is the true counter value; the bus carries its complement when i=0
  task automatic vec(input logic e, input logic i, input logic [7:0] t,
                     input logic [7:0] ev, input logic el, input logic eu,
                     input logic eo, input logic em, input logic ee,
                     input logic [7:0] ec, input string name);
    exp_t x;
    @(negedge clk);
    en   = e;
    inv  = i;
    q_in = i ? t : ~t;
    x.v    = {ev, el, eu, eo, em, ee, ec};
    x.name = name;
    sb.push_back(x);
  endtask

  // asynchronous reset: outputs must clear before the next clock edge
  task automatic do_reset(input string name);
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    #1;
    n_vec++;
    if (outs() !== 21'd0) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, outs(), 21'd0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_vec++;
        if (outs() !== x.v)
          begin
            n_fail++;
            $display("FAIL %s: got {val,lk,ud,oe,mc,err,ec}=%h expected %h",
                     x.name, outs(), x.v);
          end
      end
    end
  end

  initial begin : stim
    reset = 1'b1;
    en    = 1'b0;
    inv   = 1'b1;
    q_in  = 8'd0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (outs() !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", outs(), 21'd0);
    end
    reset = 1'b0;

    // 1: even up, true polarity
    vec(1, 1, 8'd0, 8'd0, 0, 0, 0, 0, 0, 0, "t1_s0");
    vec(1, 1, 8'd2, 8'd2, 0, 0, 0, 0, 0, 0, "t1_s2");
    vec(1, 1, 8'd4, 8'd4, 0, 0, 0, 0, 0, 0, "t1_s4");
    vec(1, 1, 8'd6, 8'd6, 0, 0, 0, 0, 0, 0, "t1_s6");
    vec(1, 1, 8'd8, 8'd8, 1, 1, 1, 0, 0, 0, "t1_lock8");
    do_reset("t1_reset");

    // 2: odd up across wrap, complemented bus
    vec(1, 0, 8'd251, 8'd251, 0, 0, 0, 0, 0, 0, "t2_s251");
    vec(1, 0, 8'd253, 8'd253, 0, 0, 0, 0, 0, 0, "t2_s253");
    vec(1, 0, 8'd255, 8'd255, 0, 0, 0, 0, 0, 0, "t2_s255");
    vec(1, 0, 8'd1,   8'd1,   0, 0, 0, 0, 0, 0, "t2_wrap1");
    vec(1, 0, 8'd3,   8'd3,   1, 1, 0, 0, 0, 0, "t2_lock3");
    do_reset("t2_reset");

    // 3: even up, then a -1 step into odd down
    vec(1, 1, 8'd2,  8'd2,  0, 0, 0, 0, 0, 0, "t3_s2");
    vec(1, 1, 8'd4,  8'd4,  0, 0, 0, 0, 0, 0, "t3_s4");
    vec(1, 1, 8'd6,  8'd6,  0, 0, 0, 0, 0, 0, "t3_s6");
    vec(1, 1, 8'd8,  8'd8,  0, 0, 0, 0, 0, 0, "t3_s8");
    vec(1, 1, 8'd10, 8'd10, 1, 1, 1, 0, 0, 0, "t3_lock10");
    vec(1, 1, 8'd12, 8'd12, 1, 1, 1, 0, 0, 0, "t3_hold12");
    vec(1, 1, 8'd11, 8'd11, 0, 1, 1, 1, 0, 0, "t3_mchg11");
    vec(1, 1, 8'd9,  8'd9,  0, 1, 1, 0, 0, 0, "t3_s9");
    vec(1, 1, 8'd7,  8'd7,  0, 1, 1, 0, 0, 0, "t3_s7");
    vec(1, 1, 8'd5,  8'd5,  0, 1, 1, 0, 0, 0, "t3_s5");
    vec(1, 1, 8'd3,  8'd3,  1, 0, 0, 0, 0, 0, "t3_lock3");
    do_reset("t3_reset");

    // 4: stall and jump errors, then relock
    vec(1, 1, 8'd12, 8'd12, 0, 0, 0, 0, 0, 0, "t4_s12");
    vec(1, 1, 8'd14, 8'd14, 0, 0, 0, 0, 0, 0, "t4_s14");
    vec(1, 1, 8'd16, 8'd16, 0, 0, 0, 0, 0, 0, "t4_s16");
    vec(1, 1, 8'd18, 8'd18, 0, 0, 0, 0, 0, 0, "t4_s18");
    vec(1, 1, 8'd20, 8'd20, 1, 1, 1, 0, 0, 0, "t4_lock20");
    vec(1, 1, 8'd20, 8'd20, 0, 1, 1, 0, 1, 1, "t4_stall");
    vec(1, 1, 8'd40, 8'd40, 0, 1, 1, 0, 1, 2, "t4_jump40");
    vec(1, 1, 8'd42, 8'd42, 0, 1, 1, 0, 0, 2, "t4_s42");
    vec(1, 1, 8'd44, 8'd44, 0, 1, 1, 0, 0, 2, "t4_s44");
    vec(1, 1, 8'd46, 8'd46, 0, 1, 1, 0, 0, 2, "t4_s46");
    vec(1, 1, 8'd48, 8'd48, 1, 1, 1, 0, 0, 2, "t4_lock48");

    // 5: en low with a changing bus, then resume
    vec(0, 1, 8'd99,  8'd48, 1, 1, 1, 0, 0, 2, "t5_off0");
    vec(0, 0, 8'd3,   8'd48, 1, 1, 1, 0, 0, 2, "t5_off1");
    vec(0, 1, 8'd200, 8'd48, 1, 1, 1, 0, 0, 2, "t5_off2");
    vec(1, 1, 8'd50,  8'd50, 1, 1, 1, 0, 0, 2, "t5_s50");
    vec(1, 1, 8'd52,  8'd52, 1, 1, 1, 0, 0, 2, "t5_s52");

    // 6: reset while locked with errors counted
    do_reset("t6_async_reset");
    vec(1, 1, 8'd77, 8'd77, 0, 0, 0, 0, 0, 0, "t6_first77");
    vec(1, 1, 8'd79, 8'd79, 0, 0, 0, 0, 0, 0, "t6_s79");

    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
